// File: rtl/mul_sched_pkg.sv
// Shared types, defaults and the round-robin pick helper
// for the shared-multiplier scheduler.
package mul_sched_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 16;
    localparam int DEF_LATENCY = 2;

    // Widest requester set supported; narrower configs use the low bits.
    localparam int MAX_REQ = 8;

    typedef struct packed {
        logic               valid;
        logic [MAX_REQ-1:0] id;
    } tag_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Rotate-and-priority search: first valid index at or after ptr,
    // wrapping modulo n.
    // Scanning from the far end lets the nearest hit overwrite the others.
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input int                 n,
        input int                 ptr
    );
        pick_t r;
        int    j;
        r = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                j = (ptr + k) % n;
                if (valid[j[2:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[2:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_pipe.sv
// LATENCY-stage unsigned multiplier, low WIDTH bits of the product.
// Ports: clk, rst (async high), a, b in; p out after LATENCY edges.
module mul_pipe
    import mul_sched_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p
);

    logic [WIDTH-1:0] st [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                st[i] <= '0;
            end
        end else begin
            st[0] <= a * b;
            for (int i = 1; i < LATENCY; i++) begin
                st[i] <= st[i-1];
            end
        end
    end

    assign p = st[LATENCY-1];

endmodule

// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one pipelined multiplier among
// NUM_REQ requesters; a tag chain returns each product one-hot.
// Ports: clk, rst; req_valid/req_a/req_b in, req_ready out;
// resp_valid/resp_p out; busy, issue_count status.
module mul_share_sched
    import mul_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]         resp_p,
    output logic                     busy,
    output logic [31:0]              issue_count
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      ptr;
    logic [MAX_REQ-1:0] vext;
    pick_t              pick;
    logic               grant;
    logic [PW-1:0]      gidx;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic [WIDTH-1:0]   pipe_p;
    logic [WIDTH-1:0]   hold_q;
    logic [31:0]        cnt_q;
    tag_t               tag_q [LATENCY];
    tag_t               tag_out;

    assign vext = MAX_REQ'(req_valid);

    always_comb begin
        pick = rr_pick(vext, NUM_REQ, int'(ptr));
    end

    // No grants while reset is held so nothing is accepted into a
    // pipeline that is being cleared.
    assign grant = pick.found && !rst;
    assign gidx  = pick.idx[PW-1:0];

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready = NUM_REQ'(1) << gidx;
        end
    end

    assign a_sel = req_a[int'(gidx)*WIDTH +: WIDTH];
    assign b_sel = req_b[int'(gidx)*WIDTH +: WIDTH];

    mul_pipe #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) u_mul (
        .clk (clk),
        .rst (rst),
        .a   (a_sel),
        .b   (b_sel),
        .p   (pipe_p)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            cnt_q <= '0;
        end else if (grant) begin
            ptr   <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            cnt_q <= cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0].valid <= grant;
            tag_q[0].id    <= MAX_REQ'(req_ready);
            for (int i = 1; i < LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_out = tag_q[LATENCY-1];

    // The multiplier shifts every cycle, so the last valid product is
    // captured here to keep resp_p steady between results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else if (tag_out.valid) begin
            hold_q <= pipe_p;
        end
    end

    assign resp_p     = tag_out.valid ? pipe_p : hold_q;
    assign resp_valid = tag_out.valid ? tag_out.id[NUM_REQ-1:0] : '0;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            busy = busy | tag_q[i].valid;
        end
    end

    assign issue_count = cnt_q;

endmodule
